// File: rtl/branch_resolve_unit.sv
// Execute-stage branch/jump resolver: checks outcome against the fetch prediction,
// issues a registered redirect plus multi-cycle flush, and owns the 2-bit BHT.
module branch_resolve_unit #(
  parameter int BHT_ENTRIES  = 64,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [31:0]      F_PC,
  output logic             F_PRED_TAKEN,
  input  logic             EX_VALID,
  input  logic [1:0]       EX_TYPE,
  input  logic [2:0]       EX_FUNCT3,
  input  logic [31:0]      EX_PC,
  input  logic [31:0]      EX_TARGET,
  input  logic             EX_PRED_TAKEN,
  input  logic             BR_EQ,
  input  logic             BR_LT,
  input  logic             BR_LTU,
  output logic             REDIRECT,
  output logic [31:0]      REDIRECT_PC,
  output logic             FLUSH,
  output logic             ILLEGAL_BR,
  output logic [CNT_W-1:0] MISPRED_CNT
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  typedef enum logic {S_IDLE, S_FLUSH} state_t;

  state_t             state_q, state_d;
  logic [2:0]         flush_cnt_q, flush_cnt_d;
  logic               redirect_q, redirect_d;
  logic [31:0]        redirect_pc_q, redirect_pc_d;
  logic               flush_q, flush_d;
  logic               illegal_q, illegal_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         bht_q [BHT_ENTRIES];
  logic [1:0]         bht_d [BHT_ENTRIES];

  logic [IDX_W-1:0]   f_idx, ex_idx;
  logic               is_branch, illegal_f3, br_taken, taken;
  logic               accepted, mispredict;
  logic [31:0]        correct_pc;
  logic               unused_pc_bits;

  assign f_idx          = F_PC[IDX_W+1:2];
  assign ex_idx         = EX_PC[IDX_W+1:2];
  assign unused_pc_bits = ^{F_PC[31:IDX_W+2], F_PC[1:0]};
  assign F_PRED_TAKEN   = bht_q[f_idx][1];

  // Resolve the instruction in EX; JALR always redirects since fetch cannot know its target.
  always_comb begin
    is_branch  = (EX_TYPE == 2'b00);
    illegal_f3 = (EX_FUNCT3[2:1] == 2'b01);
    case (EX_FUNCT3)
      3'b000:  br_taken = BR_EQ;
      3'b001:  br_taken = !BR_EQ;
      3'b100:  br_taken = BR_LT;
      3'b101:  br_taken = !BR_LT;
      3'b110:  br_taken = BR_LTU;
      3'b111:  br_taken = !BR_LTU;
      default: br_taken = 1'b0;
    endcase
    taken      = is_branch ? br_taken : 1'b1;
    accepted   = EX_VALID && (EX_TYPE != 2'b11) && (state_q == S_IDLE);
    mispredict = accepted && ((taken != EX_PRED_TAKEN) || (EX_TYPE == 2'b10));
    correct_pc = taken ? EX_TARGET : EX_PC + 32'd4;
  end

  always_comb begin
    bht_d = bht_q;
    if (accepted && is_branch && !illegal_f3) begin
      if (taken && bht_q[ex_idx] != 2'b11)
        bht_d[ex_idx] = bht_q[ex_idx] + 2'b01;
      else if (!taken && bht_q[ex_idx] != 2'b00)
        bht_d[ex_idx] = bht_q[ex_idx] - 2'b01;
    end
  end

  always_comb begin
    state_d       = state_q;
    flush_cnt_d   = flush_cnt_q;
    redirect_d    = 1'b0;
    redirect_pc_d = redirect_pc_q;
    flush_d       = flush_q;
    illegal_d     = accepted && is_branch && illegal_f3;
    cnt_d         = cnt_q;
    if (mispredict && cnt_q != {CNT_W{1'b1}})
      cnt_d = cnt_q + 1'b1;
    case (state_q)
      S_IDLE: begin
        flush_d = 1'b0;
        if (mispredict) begin
          state_d       = S_FLUSH;
          redirect_d    = 1'b1;
          redirect_pc_d = correct_pc;
          flush_d       = 1'b1;
          flush_cnt_d   = 3'(FLUSH_CYCLES - 1);
        end
      end
      S_FLUSH: begin
        if (flush_cnt_q == 3'd0) begin
          state_d = S_IDLE;
          flush_d = 1'b0;
        end else begin
          flush_cnt_d = flush_cnt_q - 3'd1;
          flush_d     = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        flush_d = 1'b0;
      end
    endcase
  end

  // Counters restart weakly not-taken so a cold entry flips after one taken outcome.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q       <= S_IDLE;
      flush_cnt_q   <= 3'd0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= 32'd0;
      flush_q       <= 1'b0;
      illegal_q     <= 1'b0;
      cnt_q         <= '0;
      for (int i = 0; i < BHT_ENTRIES; i++)
        bht_q[i] <= 2'b01;
    end else begin
      state_q       <= state_d;
      flush_cnt_q   <= flush_cnt_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
      flush_q       <= flush_d;
      illegal_q     <= illegal_d;
      cnt_q         <= cnt_d;
      bht_q         <= bht_d;
    end
  end

  assign REDIRECT    = redirect_q;
  assign REDIRECT_PC = redirect_pc_q;
  assign FLUSH       = flush_q;
  assign ILLEGAL_BR  = illegal_q;
  assign MISPRED_CNT = cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: redirect/flush timing, BHT saturation,
// flush shadowing, illegal funct3, jumps, async reset and counter saturation.
module tb_branch_resolve_unit;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b1;
  logic [31:0] F_PC = 32'd0;
  logic        F_PRED_TAKEN;
  logic        EX_VALID = 1'b0;
  logic [1:0]  EX_TYPE = 2'b00;
  logic [2:0]  EX_FUNCT3 = 3'b000;
  logic [31:0] EX_PC = 32'd0;
  logic [31:0] EX_TARGET = 32'd0;
  logic        EX_PRED_TAKEN = 1'b0;
  logic        BR_EQ = 1'b0;
  logic        BR_LT = 1'b0;
  logic        BR_LTU = 1'b0;
  logic        REDIRECT;
  logic [31:0] REDIRECT_PC;
  logic        FLUSH;
  logic        ILLEGAL_BR;
  logic [3:0]  MISPRED_CNT;

  int checks = 0;
  int errors = 0;

  branch_resolve_unit #(.BHT_ENTRIES(1024), .FLUSH_CYCLES(2), .CNT_W(4)) dut (
    .CLK(CLK), .RST_N(RST_N), .F_PC(F_PC), .F_PRED_TAKEN(F_PRED_TAKEN),
    .EX_VALID(EX_VALID), .EX_TYPE(EX_TYPE), .EX_FUNCT3(EX_FUNCT3), .EX_PC(EX_PC),
    .EX_TARGET(EX_TARGET), .EX_PRED_TAKEN(EX_PRED_TAKEN), .BR_EQ(BR_EQ),
    .BR_LT(BR_LT), .BR_LTU(BR_LTU), .REDIRECT(REDIRECT), .REDIRECT_PC(REDIRECT_PC),
    .FLUSH(FLUSH), .ILLEGAL_BR(ILLEGAL_BR), .MISPRED_CNT(MISPRED_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_ex(input logic [1:0] t, input logic [2:0] f3, input logic [31:0] pc,
                          input logic [31:0] tgt, input logic pred, input logic eq,
                          input logic lt, input logic ltu);
    EX_VALID = 1'b1; EX_TYPE = t; EX_FUNCT3 = f3; EX_PC = pc; EX_TARGET = tgt;
    EX_PRED_TAKEN = pred; BR_EQ = eq; BR_LT = lt; BR_LTU = ltu;
  endtask

  task automatic idle_ex();
    EX_VALID = 1'b0; EX_TYPE = 2'b00; EX_FUNCT3 = 3'b000; EX_PRED_TAKEN = 1'b0;
    BR_EQ = 1'b0; BR_LT = 1'b0; BR_LTU = 1'b0;
  endtask

  task automatic test_reset();
    idle_ex();
    F_PC = 32'h100;
    #1 RST_N = 1'b0;
    #2;
    checks++; if (REDIRECT !== 1'b0) begin errors++; $display("[TB] FAIL rst_redirect got %0b want 0", REDIRECT); end
    checks++; if (REDIRECT_PC !== 32'h0) begin errors++; $display("[TB] FAIL rst_redirect_pc got %h want 0", REDIRECT_PC); end
    checks++; if (FLUSH !== 1'b0) begin errors++; $display("[TB] FAIL rst_flush got %0b want 0", FLUSH); end
    checks++; if (ILLEGAL_BR !== 1'b0) begin errors++; $display("[TB] FAIL rst_illegal got %0b want 0", ILLEGAL_BR); end
    checks++; if (MISPRED_CNT !== 4'h0) begin errors++; $display("[TB] FAIL rst_cnt got %h want 0", MISPRED_CNT); end
    checks++; if (F_PRED_TAKEN !== 1'b0) begin errors++; $display("[TB] FAIL rst_pred got %0b want 0", F_PRED_TAKEN); end
    tick();
    RST_N = 1'b1;
    tick();
  endtask

  task automatic test_beq_mispredict();
    F_PC = 32'h100;
    drive_ex(2'b00, 3'b000, 32'h100, 32'h80, 1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    checks++; if (F_PRED_TAKEN !== 1'b0) begin errors++; $display("[TB] FAIL beq_pre_update_pred got %0b want 0", F_PRED_TAKEN); end
    tick();
    idle_ex();
    checks++; if (REDIRECT !== 1'b1) begin errors++; $display("[TB] FAIL beq_redirect got %0b want 1", REDIRECT); end
    checks++; if (REDIRECT_PC !== 32'h80) begin errors++; $display("[TB] FAIL beq_redirect_pc got %h want 00000080", REDIRECT_PC); end
    checks++; if (FLUSH !== 1'b1) begin errors++; $display("[TB] FAIL beq_flush1 got %0b want 1", FLUSH); end
    checks++; if (MISPRED_CNT !== 4'd1) begin errors++; $display("[TB] FAIL beq_cnt got %0d want 1", MISPRED_CNT); end
    checks++; if (F_PRED_TAKEN !== 1'b1) begin errors++; $display("[TB] FAIL beq_post_update_pred got %0b want 1", F_PRED_TAKEN); end
    tick();
    checks++; if (REDIRECT !== 1'b0) begin errors++; $display("[TB] FAIL beq_redirect_pulse got %0b want 0", REDIRECT); end
    checks++; if (FLUSH !== 1'b1) begin errors++; $display("[TB] FAIL beq_flush2 got %0b want 1", FLUSH); end
    tick();
    checks++; if (FLUSH !== 1'b0) begin errors++; $display("[TB] FAIL beq_flush_end got %0b want 0", FLUSH); end
  endtask

  task automatic test_blt_not_taken();
    drive_ex(2'b00, 3'b100, 32'h200, 32'h999, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    idle_ex();
    checks++; if (REDIRECT !== 1'b1) begin errors++; $display("[TB] FAIL blt_redirect got %0b want 1", REDIRECT); end
    checks++; if (REDIRECT_PC !== 32'h204) begin errors++; $display("[TB] FAIL blt_redirect_pc got %h want 00000204", REDIRECT_PC); end
    checks++; if (MISPRED_CNT !== 4'd2) begin errors++; $display("[TB] FAIL blt_cnt got %0d want 2", MISPRED_CNT); end
    tick();
    tick();
    F_PC = 32'h200;
    drive_ex(2'b00, 3'b100, 32'h200, 32'h999, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    idle_ex();
    checks++; if (REDIRECT !== 1'b0 || FLUSH !== 1'b0) begin errors++; $display("[TB] FAIL blt_correct_quiet got redirect=%0b flush=%0b want 0/0", REDIRECT, FLUSH); end
    checks++; if (F_PRED_TAKEN !== 1'b0) begin errors++; $display("[TB] FAIL blt_bht_floor got %0b want 0", F_PRED_TAKEN); end
    checks++; if (MISPRED_CNT !== 4'd2) begin errors++; $display("[TB] FAIL blt_cnt_hold got %0d want 2", MISPRED_CNT); end
  endtask

  task automatic test_back_to_back();
    F_PC = 32'h40;
    drive_ex(2'b00, 3'b001, 32'h40, 32'h10, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (REDIRECT !== 1'b0 || FLUSH !== 1'b0) begin errors++; $display("[TB] FAIL bne_quiet_%0d got redirect=%0b flush=%0b want 0/0", i, REDIRECT, FLUSH); end
      checks++; if (F_PRED_TAKEN !== 1'b1) begin errors++; $display("[TB] FAIL bne_pred_%0d got %0b want 1", i, F_PRED_TAKEN); end
    end
    drive_ex(2'b00, 3'b001, 32'h40, 32'h10, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    checks++; if (F_PRED_TAKEN !== 1'b1) begin errors++; $display("[TB] FAIL bne_sat_top got %0b want 1", F_PRED_TAKEN); end
    tick();
    idle_ex();
    checks++; if (F_PRED_TAKEN !== 1'b0) begin errors++; $display("[TB] FAIL bne_down_to_01 got %0b want 0", F_PRED_TAKEN); end
    checks++; if (MISPRED_CNT !== 4'd2 || REDIRECT !== 1'b0) begin errors++; $display("[TB] FAIL bne_no_mispredict got cnt=%0d redirect=%0b want 2/0", MISPRED_CNT, REDIRECT); end
  endtask

  task automatic test_flush_ignore();
    drive_ex(2'b00, 3'b000, 32'h300, 32'h500, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    drive_ex(2'b00, 3'b000, 32'h340, 32'h777, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++; if (REDIRECT !== 1'b1 || REDIRECT_PC !== 32'h500) begin errors++; $display("[TB] FAIL fl_redirect got %0b/%h want 1/00000500", REDIRECT, REDIRECT_PC); end
    tick();
    checks++; if (REDIRECT !== 1'b0 || FLUSH !== 1'b1) begin errors++; $display("[TB] FAIL fl_second got redirect=%0b flush=%0b want 0/1", REDIRECT, FLUSH); end
    tick();
    idle_ex();
    checks++; if (REDIRECT !== 1'b0 || FLUSH !== 1'b0) begin errors++; $display("[TB] FAIL fl_ignored got redirect=%0b flush=%0b want 0/0", REDIRECT, FLUSH); end
    checks++; if (MISPRED_CNT !== 4'd3) begin errors++; $display("[TB] FAIL fl_cnt got %0d want 3", MISPRED_CNT); end
    checks++; if (REDIRECT_PC !== 32'h500) begin errors++; $display("[TB] FAIL fl_pc_hold got %h want 00000500", REDIRECT_PC); end
    F_PC = 32'h340;
    #1;
    checks++; if (F_PRED_TAKEN !== 1'b0) begin errors++; $display("[TB] FAIL fl_bht_untouched got %0b want 0", F_PRED_TAKEN); end
    tick();
  endtask

  task automatic test_illegal_jumps();
    drive_ex(2'b00, 3'b010, 32'h400, 32'h900, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    idle_ex();
    checks++; if (ILLEGAL_BR !== 1'b1) begin errors++; $display("[TB] FAIL ill_pulse got %0b want 1", ILLEGAL_BR); end
    checks++; if (REDIRECT !== 1'b0 || FLUSH !== 1'b0) begin errors++; $display("[TB] FAIL ill_quiet got redirect=%0b flush=%0b want 0/0", REDIRECT, FLUSH); end
    tick();
    checks++; if (ILLEGAL_BR !== 1'b0) begin errors++; $display("[TB] FAIL ill_one_cycle got %0b want 0", ILLEGAL_BR); end
    drive_ex(2'b00, 3'b000, 32'h400, 32'h480, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    idle_ex();
    F_PC = 32'h400;
    #1;
    checks++; if (F_PRED_TAKEN !== 1'b1) begin errors++; $display("[TB] FAIL ill_bht_unchanged got %0b want 1", F_PRED_TAKEN); end
    checks++; if (REDIRECT_PC !== 32'h480 || MISPRED_CNT !== 4'd4) begin errors++; $display("[TB] FAIL ill_beq got pc=%h cnt=%0d want 00000480/4", REDIRECT_PC, MISPRED_CNT); end
    tick(); tick();
    drive_ex(2'b00, 3'b011, 32'h600, 32'h900, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    idle_ex();
    checks++; if (ILLEGAL_BR !== 1'b1 || REDIRECT !== 1'b1) begin errors++; $display("[TB] FAIL ill_pred_taken got ill=%0b redirect=%0b want 1/1", ILLEGAL_BR, REDIRECT); end
    checks++; if (REDIRECT_PC !== 32'h604 || MISPRED_CNT !== 4'd5) begin errors++; $display("[TB] FAIL ill_pred_pc got pc=%h cnt=%0d want 00000604/5", REDIRECT_PC, MISPRED_CNT); end
    tick(); tick();
    drive_ex(2'b10, 3'b000, 32'h500, 32'h3000, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    idle_ex();
    checks++; if (REDIRECT !== 1'b1 || REDIRECT_PC !== 32'h3000) begin errors++; $display("[TB] FAIL jalr_redirect got %0b/%h want 1/00003000", REDIRECT, REDIRECT_PC); end
    checks++; if (MISPRED_CNT !== 4'd6) begin errors++; $display("[TB] FAIL jalr_cnt got %0d want 6", MISPRED_CNT); end
    F_PC = 32'h500;
    #1;
    checks++; if (F_PRED_TAKEN !== 1'b0) begin errors++; $display("[TB] FAIL jalr_no_bht got %0b want 0", F_PRED_TAKEN); end
    tick(); tick();
    drive_ex(2'b01, 3'b000, 32'h700, 32'h800, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    drive_ex(2'b11, 3'b000, 32'h700, 32'h800, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (REDIRECT !== 1'b0 || MISPRED_CNT !== 4'd6) begin errors++; $display("[TB] FAIL jal_correct got redirect=%0b cnt=%0d want 0/6", REDIRECT, MISPRED_CNT); end
    tick();
    drive_ex(2'b01, 3'b000, 32'h700, 32'h800, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (REDIRECT !== 1'b0 || FLUSH !== 1'b0 || MISPRED_CNT !== 4'd6) begin errors++; $display("[TB] FAIL reserved_type got redirect=%0b flush=%0b cnt=%0d want 0/0/6", REDIRECT, FLUSH, MISPRED_CNT); end
    tick();
    idle_ex();
    checks++; if (REDIRECT !== 1'b1 || REDIRECT_PC !== 32'h800 || MISPRED_CNT !== 4'd7) begin errors++; $display("[TB] FAIL jal_mispredict got %0b/%h/%0d want 1/00000800/7", REDIRECT, REDIRECT_PC, MISPRED_CNT); end
    tick(); tick();
  endtask

  task automatic test_reset_mid_flush();
    drive_ex(2'b00, 3'b000, 32'h100, 32'h80, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    idle_ex();
    checks++; if (FLUSH !== 1'b1 || REDIRECT_PC !== 32'h104) begin errors++; $display("[TB] FAIL rmid_pre got flush=%0b pc=%h want 1/00000104", FLUSH, REDIRECT_PC); end
    #2 RST_N = 1'b0;
    #1;
    checks++; if (FLUSH !== 1'b0 || REDIRECT !== 1'b0) begin errors++; $display("[TB] FAIL rmid_clear got flush=%0b redirect=%0b want 0/0", FLUSH, REDIRECT); end
    checks++; if (MISPRED_CNT !== 4'd0 || REDIRECT_PC !== 32'h0) begin errors++; $display("[TB] FAIL rmid_state got cnt=%0d pc=%h want 0/00000000", MISPRED_CNT, REDIRECT_PC); end
    F_PC = 32'h400;
    #1;
    checks++; if (F_PRED_TAKEN !== 1'b0) begin errors++; $display("[TB] FAIL rmid_bht got %0b want 0", F_PRED_TAKEN); end
    @(posedge CLK);
    #1 RST_N = 1'b1;
    tick();
  endtask

  task automatic test_cnt_saturation();
    for (int i = 0; i < 17; i++) begin
      drive_ex(2'b10, 3'b000, 32'h900, 32'hA00, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      idle_ex();
      tick();
      tick();
      if (i == 14) begin
        checks++; if (MISPRED_CNT !== 4'hF) begin errors++; $display("[TB] FAIL sat_reach got %h want f", MISPRED_CNT); end
      end
    end
    checks++; if (MISPRED_CNT !== 4'hF) begin errors++; $display("[TB] FAIL sat_hold got %h want f", MISPRED_CNT); end
    checks++; if (FLUSH !== 1'b0 || REDIRECT_PC !== 32'hA00) begin errors++; $display("[TB] FAIL sat_end got flush=%0b pc=%h want 0/00000a00", FLUSH, REDIRECT_PC); end
  endtask

  initial begin
    test_reset();
    test_beq_mispredict();
    test_blt_not_taken();
    test_back_to_back();
    test_flush_ignore();
    test_illegal_jumps();
    test_reset_mid_flush();
    test_cnt_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
Consumer of the BR_EQ/BR_LT/BR_LTU condition flags in the pipelined OTTER execute stage. It resolves branches and jumps against the prediction carried down the pipe. On a mismatch it issues a registered PC redirect and a multi-cycle flush. It owns the 2-bit saturating branch history table (BHT) that fetch reads for predictions.

Parameters:
BHT_ENTRIES, 64, number of 2-bit counters; power of 2, >=2; index = PC[log2(BHT_ENTRIES)+1:2]
FLUSH_CYCLES, 2, cycles FLUSH stays high after a mispredict; legal 1..7
CNT_W, 16, width of the mispredict statistics counter

Ports:
CLK  in  1  rising-edge clock
RST_N  in  1  asynchronous, active-low reset
F_PC  in  32  fetch-stage PC for the BHT lookup
F_PRED_TAKEN  out  1  combinational: BHT[idx(F_PC)][1]
EX_VALID  in  1  a control-flow instruction is in EX this cycle
EX_TYPE  in  2  00 branch, 01 JAL, 10 JALR, 11 reserved (treated as not valid)
EX_FUNCT3  in  3  branch funct3
EX_PC  in  32  PC of the EX instruction
EX_TARGET  in  32  computed taken target
EX_PRED_TAKEN  in  1  prediction made at fetch for this instruction
BR_EQ  in  1  rs1 == rs2
BR_LT  in  1  signed rs1 < rs2
BR_LTU  in  1  unsigned rs1 < rs2
REDIRECT  out  1  one-cycle pulse: fetch must load REDIRECT_PC
REDIRECT_PC  out  32  corrected PC, registered
FLUSH  out  1  squash the younger IF/ID stages
ILLEGAL_BR  out  1  one-cycle pulse: branch with funct3 010 or 011
MISPRED_CNT  out  CNT_W  saturating count of mispredicts

Behaviour:
- Reset (async, RST_N=0): REDIRECT=0, REDIRECT_PC=0, FLUSH=0, ILLEGAL_BR=0, MISPRED_CNT=0, FSM=IDLE, all BHT counters=2'b01 (weakly not-taken).
- Taken resolution (combinational), branch type:
  - 000 taken=EQ; 001 taken=!EQ; 100 taken=LT; 101 taken=!LT; 110 taken=LTU; 111 taken=!LTU.
  - 010/011: taken=0, ILLEGAL_BR pulses next cycle, BHT not updated. Redirect still applies if EX_PRED_TAKEN=1.
- JAL and JALR: taken=1 always. The BHT is updated for the branch type only.
- Mispredict = accepted & (taken != EX_PRED_TAKEN). JALR always counts as a mispredict, because fetch cannot know the register target.
- Accepted = EX_VALID & EX_TYPE != 11 & FSM == IDLE.
- Correct PC = taken ? EX_TARGET : EX_PC + 4 (32-bit wrap).
- FSM states:
  - IDLE: on accepted mispredict at edge N, load REDIRECT_PC and flush counter = FLUSH_CYCLES-1, then go to FLUSH.
  - FLUSH: FLUSH=1. Decrement the counter each cycle; when the counter is 0 at an edge, return to IDLE.
- Timing:
  - REDIRECT=1 only in the first FLUSH cycle (cycle N+1).
  - FLUSH=1 for cycles N+1 .. N+FLUSH_CYCLES.
  - Latency from the mispredicting EX cycle to REDIRECT is 1 cycle.
- While FLUSH=1, EX_VALID is ignored: no BHT update, no redirect, no counting, no ILLEGAL_BR.
- BHT update at the edge of an accepted branch: taken increments the counter (saturate at 11), not-taken decrements it (saturate at 00).
- Same-cycle lookup and update to the same index: F_PRED_TAKEN reflects the pre-update value; the new value is visible from the next cycle.
- MISPRED_CNT increments by 1 per accepted mispredict and holds at all-ones (no wrap).
- Reset asserted mid-FLUSH: outputs clear immediately, and the BHT and counter reinitialise.
- Correct predictions produce no REDIRECT and no FLUSH; back-to-back correct branches are accepted every cycle.

Test Plan:
- Reset, then F_PC=0x100 -> F_PRED_TAKEN=0. EX branch BEQ, PC=0x100, EQ=1, pred=0, target=0x80 -> next cycle REDIRECT=1, REDIRECT_PC=0x80. FLUSH high for exactly 2 cycles. MISPRED_CNT=1.
- BLT not taken, PC=0x200, LT=0, pred=1 -> REDIRECT_PC=0x204. The BHT entry for 0x200 goes 01->00 (a second untaken branch keeps it at 00).
- Three taken BNE at PC=0x40, each predicted correctly as seen by the bench -> counter sequence 01->10->11->11. F_PRED_TAKEN for 0x40 becomes 1 after the first update. No REDIRECT is raised when EX_PRED_TAKEN matches.
- Mispredict, then EX_VALID=1 with another mispredict during both FLUSH cycles -> only one REDIRECT, MISPRED_CNT +1 only, and no BHT change from the ignored instructions.
- funct3=010, pred=0 -> ILLEGAL_BR pulses once, no REDIRECT, BHT unchanged. JALR, target=0x3000 -> REDIRECT_PC=0x3000 regardless of pred.
- Assert RST_N=0 in the middle of FLUSH -> FLUSH=0 and REDIRECT=0 asynchronously, MISPRED_CNT=0, all BHT lookups return 0. Force MISPRED_CNT to all-ones (CNT_W=4, 16+ mispredicts) -> the counter holds at 0xF.
